// File: rtl/mux_nx1_rr_reg.sv
// mux_nx1_rr_reg: N:1 registered valid/ready mux, explicit-select or round-robin per mode
// Optional 16-bit transfer counter port cnt under MUX_NX1_CNT_EN
module mux_nx1_rr_reg #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_grant,
  input  logic           out_ready
`ifdef MUX_NX1_CNT_EN
  ,output logic [15:0]   cnt
`endif
);
  logic [SW-1:0] ptr, rr_c, c;
  logic          rr_hit, hit, load_ok, xfer;
  // First valid channel scanning ptr, ptr+1, ... wrapping at N (not 2^SW)
  always_comb begin
    rr_hit = 1'b0;
    rr_c   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!rr_hit && in_valid[j]) begin
        rr_hit = 1'b1;
        rr_c   = SW'(j);
      end
    end
  end
  assign load_ok  = !out_valid || out_ready;
  assign c        = mode ? rr_c : sel;
  assign hit      = mode ? rr_hit : (int'(sel) < N);
  assign in_ready = hit ? (N'(load_ok) << c) : '0;
  assign xfer     = hit && in_valid[c] && load_ok;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(c)*W +: W];
      out_grant <= c;
      if (mode) ptr <= (int'(c) == N-1) ? '0 : c + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef MUX_NX1_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (xfer) cnt <= cnt + 16'd1;
  end
`endif
endmodule
